// File: rtl/btn_conditioner.sv
// Button/switch front-end: synchronises the raw confirm button and switches,
// debounces the button, and emits one-cycle press / release / long-press
// pulses plus a switch snapshot taken on every accepted press.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 200_000_000,
  parameter int SW_WIDTH          = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                btn_raw,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic                btn_level,
  output logic                press_pulse,
  output logic                release_pulse,
  output logic                long_press_pulse,
  output logic [SW_WIDTH-1:0] sw_sync,
  output logic [SW_WIDTH-1:0] sw_snapshot,
  output logic                snapshot_valid
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    DISARMING = 2'd3
  } state_t;

  logic                btn_meta_q, btn_s_q;
  logic [SW_WIDTH-1:0] sw_meta_q, sw_sync_q;

  state_t              state_q, state_d;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                long_fired_q, long_fired_d;
  logic                level_q, level_d;
  logic                press_q, press_d;
  logic                release_q, release_d;
  logic                long_q, long_d;
  logic [SW_WIDTH-1:0] snap_q, snap_d;
  logic                snap_vld_q, snap_vld_d;

  // Two-flop synchronisers for the button and the switch bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      btn_meta_q <= btn_raw;
      btn_s_q    <= btn_meta_q;
      sw_meta_q  <= sw_raw;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // Debounce FSM state, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= RELEASED;
      db_cnt_q     <= '0;
      hold_cnt_q   <= '0;
      long_fired_q <= 1'b0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_q       <= 1'b0;
      snap_q       <= '0;
      snap_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      long_fired_q <= long_fired_d;
      level_q      <= level_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_q       <= long_d;
      snap_q       <= snap_d;
      snap_vld_q   <= snap_vld_d;
    end
  end

  // Next-state logic; pulses default low so they are one cycle wide.
  always_comb begin
    state_d      = state_q;
    db_cnt_d     = db_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    long_fired_d = long_fired_q;
    level_d      = level_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    long_d       = 1'b0;
    snap_d       = snap_q;
    snap_vld_d   = snap_vld_q;
    case (state_q)
      RELEASED: begin
        if (btn_s_q) begin
          state_d  = ARMING;
          db_cnt_d = '0;
        end
      end
      ARMING: begin
        if (!btn_s_q) begin
          state_d = RELEASED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d      = PRESSED;
          press_d      = 1'b1;
          level_d      = 1'b1;
          snap_d       = sw_sync_q;
          snap_vld_d   = 1'b1;
          hold_cnt_d   = '0;
          long_fired_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s_q) begin
          state_d  = DISARMING;
          db_cnt_d = '0;
        end
        // Hold time keeps counting on the edge that leaves for DISARMING, so
        // a bounce delays the long press by exactly the cycles spent there.
        if (!long_fired_q) begin
          if (hold_cnt_q == HOLD_LAST) begin
            long_d       = 1'b1;
            long_fired_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      DISARMING: begin
        if (btn_s_q) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = RELEASED;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  assign btn_level        = level_q;
  assign press_pulse      = press_q;
  assign release_pulse    = release_q;
  assign long_press_pulse = long_q;
  assign sw_sync          = sw_sync_q;
  assign sw_snapshot      = snap_q;
  assign snapshot_valid   = snap_vld_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenario tasks plus a randomized run,
// with a cycle-level reference model built from run-length rules.
module tb_btn_conditioner;
  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int SW  = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          btn_raw = 1'b0;
  logic [SW-1:0] sw_raw = '0;
  logic          btn_level, press_pulse, release_pulse, long_press_pulse, snapshot_valid;
  logic [SW-1:0] sw_sync, sw_snapshot;

  int n_assert = 0;
  int n_fail   = 0;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LNG), .SW_WIDTH(SW)) dut (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_press_pulse(long_press_pulse), .sw_sync(sw_sync), .sw_snapshot(sw_snapshot),
    .snapshot_valid(snapshot_valid)
  );

  always #5 clock = ~clock;

  // Reference model: a level change is accepted once the synchronised button
  // has disagreed with the accepted level for DEB+1 consecutive edges; hold
  // time advances on every edge that starts with no pending disagreement.
  logic          m_s1, m_s2, e_lvl, e_press, e_rel, e_long, e_vld, m_fired;
  logic [SW-1:0] m_sw1, m_sw2, e_snap;
  int            m_run, m_held;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_s1 <= 0; m_s2 <= 0; m_sw1 <= '0; m_sw2 <= '0;
      e_lvl <= 0; e_press <= 0; e_rel <= 0; e_long <= 0; e_vld <= 0; e_snap <= '0;
      m_run <= 0; m_held <= 0; m_fired <= 0;
    end else begin : mdl_step
      int run, held;
      bit fired, lvl, p, r, lp;
      run = m_run; held = m_held; fired = m_fired; lvl = e_lvl; p = 0; r = 0; lp = 0;
      if (lvl && run == 0 && !fired) begin
        held = held + 1;
        if (held == LNG) begin lp = 1; fired = 1; end
      end
      if (m_s2 != lvl) run = run + 1; else run = 0;
      if (run == DEB + 1) begin
        run = 0;
        if (!lvl) begin
          p = 1; held = 0; fired = 0;
          e_snap <= m_sw2; e_vld <= 1'b1;
        end else r = 1;
        lvl = !lvl;
      end
      m_s1 <= btn_raw; m_s2 <= m_s1; m_sw1 <= sw_raw; m_sw2 <= m_sw1;
      m_run <= run; m_held <= held; m_fired <= fired;
      e_lvl <= lvl; e_press <= p; e_rel <= r; e_long <= lp;
    end
  end

  // Scoreboard: every falling edge, all outputs against the model.
  always @(negedge clock) begin
    n_assert++;
    if ({btn_level, press_pulse, release_pulse, long_press_pulse, snapshot_valid, sw_sync, sw_snapshot} !==
        {e_lvl, e_press, e_rel, e_long, e_vld, m_sw2, e_snap}) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t got lvl/p/r/l/v=%b%b%b%b%b sync=%h snap=%h, want %b%b%b%b%b sync=%h snap=%h",
               $time, btn_level, press_pulse, release_pulse, long_press_pulse, snapshot_valid, sw_sync, sw_snapshot,
               e_lvl, e_press, e_rel, e_long, e_vld, m_sw2, e_snap);
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_assert++;
    if ({btn_level, press_pulse, release_pulse, long_press_pulse, snapshot_valid, sw_sync, sw_snapshot} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got lvl=%b p=%b r=%b l=%b v=%b sync=%h snap=%h, want all 0",
               btn_level, press_pulse, release_pulse, long_press_pulse, snapshot_valid, sw_sync, sw_snapshot);
    end
    #2 reset = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_clean_press();
    @(negedge clock);
    sw_raw = 16'hA5C3; btn_raw = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock); #1;
      n_assert++;
      if (press_pulse !== (k == 6)) begin
        n_fail++;
        $display("FAIL clean_press edge %0d press_pulse=%b want %b", k, press_pulse, (k == 6));
      end
    end
    n_assert++;
    if ({btn_level, snapshot_valid, sw_snapshot} !== {1'b1, 1'b1, 16'hA5C3}) begin
      n_fail++;
      $display("FAIL clean_press_state lvl=%b vld=%b snap=%h want 1 1 a5c3", btn_level, snapshot_valid, sw_snapshot);
    end
    @(negedge clock); btn_raw = 1'b0;
    repeat (12) @(negedge clock);
  endtask

  task automatic test_bounce();
    bit seq [7] = '{1, 0, 1, 1, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clock); btn_raw = seq[i];
    end
    for (int k = 0; k < 20; k++) begin
      @(posedge clock); #1;
      n_assert++;
      if ({btn_level, press_pulse, release_pulse, long_press_pulse} !== 4'b0) begin
        n_fail++;
        $display("FAIL bounce cycle %0d lvl/p/r/l=%b%b%b%b want 0000", k,
                 btn_level, press_pulse, release_pulse, long_press_pulse);
      end
    end
  endtask

  task automatic test_long_hold();
    bit found = 0;
    int cnt = 0;
    @(negedge clock); btn_raw = 1'b1;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clock); #1;
      if (press_pulse === 1'b1) found = 1;
    end
    n_assert++;
    if (!found) begin n_fail++; $display("FAIL long_hold_press press_pulse=0 want 1 within 20 edges"); end
    for (int j = 1; j <= 40; j++) begin
      @(posedge clock); #1;
      if (long_press_pulse === 1'b1) cnt++;
      n_assert++;
      if (long_press_pulse !== (j == LNG)) begin
        n_fail++;
        $display("FAIL long_hold edge +%0d long_press_pulse=%b want %b", j, long_press_pulse, (j == LNG));
      end
    end
    n_assert++;
    if (cnt != 1) begin n_fail++; $display("FAIL long_hold_count got %0d want 1", cnt); end
    @(negedge clock); btn_raw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock); #1;
      n_assert++;
      if (release_pulse !== (k == 6)) begin
        n_fail++;
        $display("FAIL long_release edge %0d release_pulse=%b want %b", k, release_pulse, (k == 6));
      end
    end
  endtask

  task automatic test_bounce_held();
    bit found = 0;
    @(negedge clock); btn_raw = 1'b1;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clock); #1;
      if (press_pulse === 1'b1) found = 1;
    end
    n_assert++;
    if (!found) begin n_fail++; $display("FAIL bounce_held_press press_pulse=0 want 1 within 20 edges"); end
    for (int j = 1; j <= 30; j++) begin
      @(negedge clock); btn_raw = !(j == 5 || j == 6);
      @(posedge clock); #1;
      n_assert++;
      if ({long_press_pulse, release_pulse} !== {(j == LNG + 2), 1'b0}) begin
        n_fail++;
        $display("FAIL bounce_held edge +%0d long/rel=%b%b want %b0", j,
                 long_press_pulse, release_pulse, (j == LNG + 2));
      end
    end
    @(negedge clock); btn_raw = 1'b0;
    repeat (12) @(negedge clock);
  endtask

  task automatic test_snapshot_hold();
    @(negedge clock); sw_raw = 16'h0001; btn_raw = 1'b1;
    repeat (10) @(negedge clock);
    sw_raw = 16'hFFFF;
    repeat (5) @(negedge clock);
    btn_raw = 1'b0;
    repeat (12) @(negedge clock);
    #1;
    n_assert++;
    if ({sw_snapshot, sw_sync, btn_level} !== {16'h0001, 16'hFFFF, 1'b0}) begin
      n_fail++;
      $display("FAIL snapshot_hold snap=%h sync=%h lvl=%b want 0001 ffff 0", sw_snapshot, sw_sync, btn_level);
    end
    @(negedge clock); btn_raw = 1'b1;
    repeat (10) @(negedge clock);
    #1;
    n_assert++;
    if (sw_snapshot !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL snapshot_second snap=%h want ffff", sw_snapshot);
    end
    @(negedge clock); btn_raw = 1'b0;
    repeat (12) @(negedge clock);
  endtask

  task automatic test_reset_mid_press();
    @(negedge clock); sw_raw = 16'h1234; btn_raw = 1'b1;
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    n_assert++;
    if ({btn_level, press_pulse, release_pulse, long_press_pulse, snapshot_valid, sw_sync, sw_snapshot} !== '0) begin
      n_fail++;
      $display("FAIL reset_async lvl=%b p=%b r=%b l=%b v=%b sync=%h snap=%h want all 0",
               btn_level, press_pulse, release_pulse, long_press_pulse, snapshot_valid, sw_sync, sw_snapshot);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock); #1;
      n_assert++;
      if ({press_pulse, release_pulse} !== {(k == 6), 1'b0}) begin
        n_fail++;
        $display("FAIL reset_repress edge %0d p/r=%b%b want %b0", k, press_pulse, release_pulse, (k == 6));
      end
    end
    @(negedge clock); btn_raw = 1'b0;
    repeat (12) @(negedge clock);
  endtask

  task automatic test_random();
    int left = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock);
      if (left == 0) begin
        btn_raw = $urandom_range(0, 1);
        left = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 35) : $urandom_range(1, 8);
      end
      left--;
      if ($urandom_range(0, 9) == 0) sw_raw = SW'($urandom);
    end
    @(negedge clock); btn_raw = 1'b0;
    repeat (12) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_bounce_held();
    test_snapshot_hold();
    test_reset_mid_press();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
